// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage payload field layout, control vectors,
// and the skid buffer state encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    // Payload layouts, LSB first
    localparam int IF_ID_INSTR_LSB = 0;
    localparam int IF_ID_PC_LSB    = IF_ID_INSTR_LSB + XLEN;
    localparam int IF_ID_DATA_W    = IF_ID_PC_LSB + XLEN;

    localparam int ID_EX_RD_LSB    = 0;
    localparam int ID_EX_RS2_LSB   = ID_EX_RD_LSB + REG_W;
    localparam int ID_EX_RS1_LSB   = ID_EX_RS2_LSB + REG_W;
    localparam int ID_EX_IMM_LSB   = ID_EX_RS1_LSB + REG_W;
    localparam int ID_EX_RS2V_LSB  = ID_EX_IMM_LSB + XLEN;
    localparam int ID_EX_RS1V_LSB  = ID_EX_RS2V_LSB + XLEN;
    localparam int ID_EX_PC_LSB    = ID_EX_RS1V_LSB + XLEN;
    localparam int ID_EX_DATA_W    = ID_EX_PC_LSB + XLEN;

    localparam int EX_MEM_RD_LSB   = 0;
    localparam int EX_MEM_STD_LSB  = EX_MEM_RD_LSB + REG_W;
    localparam int EX_MEM_ALU_LSB  = EX_MEM_STD_LSB + XLEN;
    localparam int EX_MEM_DATA_W   = EX_MEM_ALU_LSB + XLEN;

    localparam int MEM_WB_RD_LSB   = 0;
    localparam int MEM_WB_VAL_LSB  = MEM_WB_RD_LSB + REG_W;
    localparam int MEM_WB_DATA_W   = MEM_WB_VAL_LSB + XLEN;

    typedef struct packed {
        logic       pred_taken;
        logic       illegal;
        logic [5:0] rsvd;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] alu_op;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic       br_taken;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [5:0] rsvd;
    } mem_wb_ctrl_t;

    localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    localparam if_id_ctrl_t  IF_ID_CTRL_RST  = '0;
    localparam id_ex_ctrl_t  ID_EX_CTRL_RST  = '0;
    localparam ex_mem_ctrl_t EX_MEM_CTRL_RST = '0;
    localparam mem_wb_ctrl_t MEM_WB_CTRL_RST = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry stage buffer with a registered in_ready; the skid entry absorbs
// the one input accepted while downstream stalls.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state, state_n;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              rdy_q;
    logic              xfer_in;
    logic              ld_main, ld_skid, from_skid, clr_main;

    assign in_ready  = rdy_q;
    assign xfer_in   = in_valid && rdy_q;
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_comb begin
        state_n   = state;
        ld_main   = 1'b0;
        ld_skid   = 1'b0;
        from_skid = 1'b0;
        clr_main  = 1'b0;
        if (flush) begin
            state_n  = EMPTY;
            clr_main = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        state_n = ONE;
                        ld_main = 1'b1;
                    end
                end
                ONE: begin
                    if (xfer_in && out_ready) begin
                        ld_main = 1'b1;
                    end else if (xfer_in) begin
                        state_n = TWO;
                        ld_skid = 1'b1;
                    end else if (out_ready) begin
                        state_n  = EMPTY;
                        clr_main = 1'b1;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state_n   = ONE;
                        ld_main   = 1'b1;
                        from_skid = 1'b1;
                    end
                end
                default: begin
                    state_n  = EMPTY;
                    clr_main = 1'b1;
                end
            endcase
        end
    end

    // in_ready stays low through reset and rises on the first edge after
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n != TWO);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (ld_main) begin
            main_ctrl <= from_skid ? skid_ctrl : in_ctrl;
            main_data <= from_skid ? skid_data : in_data;
        end else if (clr_main) begin
            main_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (ld_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with handshake, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic bubble;

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );
`else
    logic xfer_in;

    assign in_ready = out_ready || !out_valid;
    assign xfer_in  = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end

    // Payload only clears when configured to; otherwise it just holds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data <= '0;
        end else if (flush) begin
            if (CLEAR_DATA != 0) begin
                out_data <= '0;
            end
        end else if (xfer_in) begin
            out_data <= in_data;
        end else if (out_ready && (CLEAR_DATA != 0)) begin
            out_data <= '0;
        end
    end
`endif

    assign bubble = !out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (hold/clear payload, wide/narrow
// counter) driven together and checked against a queue-based reference.
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 8;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy0, rdy1, v0, v1;
    logic [CW-1:0] c0, c1;
    logic [DW-1:0] d0, d1;
    logic [15:0]   cnt0;
    logic [1:0]    cnt1;

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0), .CNT_W(16)
    ) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v0), .out_ready(out_ready),
        .out_ctrl(c0), .out_data(d0), .bubble_cnt(cnt0)
    );

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1), .CNT_W(2)
    ) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ready(out_ready),
        .out_ctrl(c1), .out_data(d1), .bubble_cnt(cnt1)
    );

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] hold;
    int            m_cnt0, m_cnt1;
    bit            rdy_ok;
    bit            exp_rdy;
    int            tests = 0;
    int            fails = 0;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        bit            v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        v = (q.size() != 0);
        c = v ? q[0].ctrl : '0;
        d = v ? q[0].data : hold;
        if (SKID) exp_rdy = rdy_ok && (q.size() < 2);
        else      exp_rdy = out_ready || !v;
        chk("valid0", 64'(v0), 64'(v));
        chk("ctrl0", 64'(c0), 64'(c));
        chk("data0", d0, d);
        chk("ready0", 64'(rdy0), 64'(exp_rdy));
        chk("cnt0", 64'(cnt0), 64'(m_cnt0));
        chk("valid1", 64'(v1), 64'(v));
        chk("ctrl1", 64'(c1), 64'(c));
        chk("data1", d1, v ? d : 64'h0);
        chk("ready1", 64'(rdy1), 64'(exp_rdy));
        chk("cnt1", 64'(cnt1), 64'(m_cnt1));
    endtask

    task automatic update();
        bit   v;
        ent_t e;
        v = (q.size() != 0);
        if (!v && out_ready) begin
            if (m_cnt0 < 65535) m_cnt0++;
            if (m_cnt1 < 3) m_cnt1++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (v && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                e.ctrl = in_ctrl;
                e.data = in_data;
                q.push_back(e);
            end
        end
        if (q.size() != 0) hold = q[0].data;
        rdy_ok = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clock);
        check();
        @(posedge clock);
        update();
        #1;
    endtask

    task automatic drive(input bit f, input bit iv, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input bit ordy);
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        q.delete();
        hold   = '0;
        m_cnt0 = 0;
        m_cnt1 = 0;
        rdy_ok = 1'b0;
        #1;
        check();
        repeat (n) begin
            @(negedge clock);
            check();
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = '1;
        out_ready = 1'b1;
        do_reset(3);

        // idle: counter counts, narrow one saturates
        repeat (7) drive(0, 0, 8'h00, 64'h0, 1);
        chk("bubble_cnt0_7", 64'(cnt0), 64'd7);
        chk("bubble_cnt1_sat", 64'(cnt1), 64'd3);

        // streaming
        for (int i = 0; i < 10; i++)
            drive(0, 1, 8'(i + 1), 64'(i), 1);
        repeat (2) drive(0, 0, 8'h00, 64'h0, 1);

        // stall with an upstream that keeps offering
        drive(0, 1, 8'h11, 64'hDEAD, 1);
        repeat (4) drive(0, 1, 8'h22, 64'hBEEF, 0);
        repeat (3) drive(0, 0, 8'h00, 64'h0, 1);

        // flush while valid
        drive(0, 1, 8'h5A, 64'h5A5A, 1);
        drive(1, 0, 8'h00, 64'h0, 0);
        drive(0, 0, 8'h00, 64'h0, 0);
        chk("flush_hold_data0", d0, 64'h5A5A);
        chk("flush_clear_data1", d1, 64'h0);

        // flush with a full stage (both entries in skid mode)
        drive(0, 1, 8'h31, 64'h3131, 0);
        drive(0, 1, 8'h32, 64'h3232, 0);
        drive(0, 1, 8'h33, 64'h3333, 0);
        drive(1, 0, 8'h00, 64'h0, 0);
        repeat (2) drive(0, 0, 8'h00, 64'h0, 1);

        // flush coinciding with an accepted input
        drive(1, 1, 8'h77, 64'h7777, 1);
        drive(0, 0, 8'h00, 64'h0, 0);
        chk("flush_drop_valid", 64'(v0), 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0);

        // reset in the middle of a stall
        drive(0, 1, 8'h44, 64'hDEAD, 1);
        drive(0, 1, 8'h45, 64'hCAFE, 0);
        do_reset(2);
        repeat (4) drive(0, 1, 8'h46, 64'h4646, 1);
        repeat (2) drive(0, 0, 8'h00, 64'h0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
